// File: rtl/tx_arb_pkg.sv
// Shared types and constants for the two-source UART block arbiter.
package tx_arb_pkg;

    localparam int         BLOCK_W      = 128;
    localparam int         CNT_W        = 5;
    localparam logic [7:0] TAG0_DEFAULT = 8'hC0;
    localparam logic [7:0] TAG1_DEFAULT = 8'hD1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_START = 2'd2,
        ST_WAIT  = 2'd3
    } state_e;

    function automatic logic [7:0] tag_for(input logic src, input logic [7:0] t0,
                                           input logic [7:0] t1);
        return src ? t1 : t0;
    endfunction

endpackage

// File: rtl/tx_block_arbiter_rr_arb2.sv
// Two-way round-robin picker; the last-grant state is held by the caller.
module rr_arb2
    import tx_arb_pkg::*;
(
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic last_grant_i,
    output logic grant_valid_o,
    output logic grant_idx_o
);

    always_comb begin
        grant_valid_o = valid0_i | valid1_i;
        // On a tie the source that did not win last time goes next.
        if (valid0_i && valid1_i) begin
            grant_idx_o = ~last_grant_i;
        end else begin
            grant_idx_o = valid1_i;
        end
    end

endmodule

// File: rtl/tx_block_arbiter.sv
// Latches one 128-bit block from two producers and streams an optional tag
// byte plus the data bytes, MSB first, over the UART tx_start/tx_done handshake.
module tx_block_arbiter
    import tx_arb_pkg::*;
#(
    parameter int         NUM_BYTES = 16,
    parameter int         TAG_EN    = 1,
    parameter logic [7:0] TAG0      = TAG0_DEFAULT,
    parameter logic [7:0] TAG1      = TAG1_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req0_valid,
    input  logic [NUM_BYTES*8-1:0] req0_data,
    output logic                   ack0,
    input  logic                   req1_valid,
    input  logic [NUM_BYTES*8-1:0] req1_data,
    output logic                   ack1,
    input  logic                   tx_done,
    output logic                   tx_start,
    output logic [7:0]             d_out,
    output logic                   busy,
    output logic                   active_src
);

    localparam int               BW       = NUM_BYTES * 8;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES + TAG_EN);

    state_e           state_q;
    logic [BW-1:0]    shift_q, shift_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       d_out_q, d_out_d;
    logic             last_grant_q;
    logic             ack0_q, ack1_q;
    logic             tx_start_q;
    logic             busy_q;
    logic             active_src_q;
    logic             tag_slot;
    logic             grant_valid;
    logic             grant_idx;

    rr_arb2 u_rr (
        .valid0_i      (req0_valid),
        .valid1_i      (req1_valid),
        .last_grant_i  (last_grant_q),
        .grant_valid_o (grant_valid),
        .grant_idx_o   (grant_idx)
    );

    // Byte slot 0 carries the tag when tagging is on; otherwise every slot is data.
    always_comb begin
        tag_slot = (TAG_EN != 0) && (cnt_q == '0);
        d_out_d  = tag_slot ? tag_for(active_src_q, TAG0, TAG1) : shift_q[BW-1 -: 8];
        shift_d  = tag_slot ? shift_q : (shift_q << 8);
        cnt_d    = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            d_out_q      <= '0;
            last_grant_q <= 1'b1;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            tx_start_q   <= 1'b0;
            busy_q       <= 1'b0;
            active_src_q <= 1'b0;
        end else begin
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            tx_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_valid) begin
                        shift_q      <= grant_idx ? req1_data : req0_data;
                        active_src_q <= grant_idx;
                        last_grant_q <= grant_idx;
                        cnt_q        <= '0;
                        ack0_q       <= ~grant_idx;
                        ack1_q       <= grant_idx;
                        busy_q       <= 1'b1;
                        state_q      <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    tx_start_q <= 1'b1;
                    d_out_q    <= d_out_d;
                    state_q    <= ST_START;
                end
                ST_START: begin
                    shift_q <= shift_d;
                    cnt_q   <= cnt_d;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tx_done) begin
                        if (cnt_q == LAST_CNT) begin
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end else begin
                            tx_start_q <= 1'b1;
                            d_out_q    <= d_out_d;
                            state_q    <= ST_START;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ack0       = ack0_q;
    assign ack1       = ack1_q;
    assign tx_start   = tx_start_q;
    assign d_out      = d_out_q;
    assign busy       = busy_q;
    assign active_src = active_src_q;

endmodule

// File: tb/tb_tx_block_arbiter.sv
// Scoreboard bench for tx_block_arbiter: a UART model answers each tx_start and
// logs {active_src, d_out}; scenario tasks queue expected bytes and compare.
module tb_tx_block_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         resetn;
    logic         r0v, r1v;
    logic [127:0] r0d, r1d;
    logic         u_done, si_done, ss_done, tx_done_a;
    logic         ack0, ack1, start, busy, asrc;
    logic [7:0]   dout;

    logic         b_r0v, b_r1v, b_done;
    logic [127:0] b_r0d, b_r1d;
    logic         b_ack0, b_ack1, b_start, b_busy, b_asrc;
    logic [7:0]   b_dout;

    logic         spur_en;

    logic [8:0]   exp_q[$];
    logic [8:0]   obs_q[$];
    logic [7:0]   b_exp_q[$];
    logic [7:0]   b_obs_q[$];
    bit           gnt_q[$];
    int           gnt_done_q[$];

    int start_cnt, done_cnt, ack0_cnt, ack1_cnt, b_start_cnt;
    int checks, failures;

    assign tx_done_a = u_done | si_done | ss_done;

    tx_block_arbiter u_dut (
        .clk        (clk),
        .reset      (resetn),
        .req0_valid (r0v),
        .req0_data  (r0d),
        .ack0       (ack0),
        .req1_valid (r1v),
        .req1_data  (r1d),
        .ack1       (ack1),
        .tx_done    (tx_done_a),
        .tx_start   (start),
        .d_out      (dout),
        .busy       (busy),
        .active_src (asrc)
    );

    tx_block_arbiter #(.TAG_EN(0)) u_dut_nt (
        .clk        (clk),
        .reset      (resetn),
        .req0_valid (b_r0v),
        .req0_data  (b_r0d),
        .ack0       (b_ack0),
        .req1_valid (b_r1v),
        .req1_data  (b_r1d),
        .ack1       (b_ack1),
        .tx_done    (b_done),
        .tx_start   (b_start),
        .d_out      (b_dout),
        .busy       (b_busy),
        .active_src (b_asrc)
    );

    // UART model: tx_done arrives ten cycles after each tx_start.
    initial begin
        u_done = 1'b0; start_cnt = 0; done_cnt = 0;
        forever begin
            @(negedge clk);
            u_done = 1'b0;
            if (start === 1'b1) begin
                obs_q.push_back({asrc, dout});
                start_cnt++;
                repeat (9) @(negedge clk);
                u_done = 1'b1;
                done_cnt++;
            end
        end
    end

    initial begin
        b_done = 1'b0; b_start_cnt = 0;
        forever begin
            @(negedge clk);
            b_done = 1'b0;
            if (b_start === 1'b1) begin
                b_obs_q.push_back(b_dout);
                b_start_cnt++;
                repeat (9) @(negedge clk);
                b_done = 1'b1;
            end
        end
    end

    // Spurious tx_done aimed at the posedge that leaves START.
    initial begin
        ss_done = 1'b0;
        forever begin
            @(negedge clk);
            ss_done = spur_en && (start === 1'b1);
        end
    end

    initial begin
        ack0_cnt = 0; ack1_cnt = 0;
        forever begin
            @(negedge clk);
            if (ack0 === 1'b1) begin
                ack0_cnt++; gnt_q.push_back(1'b0); gnt_done_q.push_back(done_cnt);
            end
            if (ack1 === 1'b1) begin
                ack1_cnt++; gnt_q.push_back(1'b1); gnt_done_q.push_back(done_cnt);
            end
        end
    end

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ack0, ack1, start, busy, asrc} !== 5'b0) begin
            failures++; $display("FAIL reset_ctrl got=%b want=00000", {ack0, ack1, start, busy, asrc});
        end
        checks++;
        if (dout !== 8'h00) begin
            failures++; $display("FAIL reset_dout got=%h want=00", dout);
        end
        checks++;
        if ({b_ack0, b_ack1, b_start, b_busy, b_asrc, b_dout} !== 13'b0) begin
            failures++; $display("FAIL reset_notag got=%b want=0", {b_ack0, b_ack1, b_start, b_busy, b_asrc, b_dout});
        end
        resetn = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || start !== 1'b0) begin
            failures++; $display("FAIL reset_idle busy=%b start=%b want=0,0", busy, start);
        end
    endtask

    task automatic test_single();
        logic [127:0] d;
        logic [8:0]   e, o;
        int           s0, d0;
        d = 128'h00112233445566778899AABBCCDDEEFF;
        exp_q.push_back({1'b0, 8'hC0});
        for (int k = 0; k < 16; k++) exp_q.push_back({1'b0, d[127-8*k -: 8]});
        s0 = start_cnt; d0 = done_cnt;
        r0d = d; r0v = 1'b1;
        @(negedge clk);
        checks++;
        if (ack0 !== 1'b1 || start !== 1'b0) begin
            failures++; $display("FAIL single_ack ack0=%b start=%b want=1,0", ack0, start);
        end
        r0v = 1'b0;
        @(negedge clk);
        checks++;
        if (start !== 1'b1 || ack0 !== 1'b0 || dout !== 8'hC0) begin
            failures++; $display("FAIL single_first start=%b ack0=%b dout=%h want=1,0,c0", start, ack0, dout);
        end
        checks++;
        if (busy !== 1'b1 || asrc !== 1'b0) begin
            failures++; $display("FAIL single_busy busy=%b src=%b want=1,0", busy, asrc);
        end
        for (int i = 0; i < 400 && busy === 1'b1; i++) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL single_timeout busy=%b want=0", busy);
        end
        checks++;
        if (start_cnt - s0 != 17 || done_cnt - d0 != 17) begin
            failures++; $display("FAIL single_count starts=%0d dones=%0d want=17,17", start_cnt - s0, done_cnt - d0);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL single_len got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++; $display("FAIL single_byte[%0d] got=%h want=%h", i, o, e);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_both();
        logic [8:0] e, o;
        int         d0;
        resetn = 1'b0; @(negedge clk); resetn = 1'b1;
        gnt_q.delete(); gnt_done_q.delete();
        d0 = done_cnt;
        for (int b = 0; b < 3; b++) begin
            exp_q.push_back((b % 2 == 0) ? {1'b0, 8'hC0} : {1'b1, 8'hD1});
            for (int k = 0; k < 16; k++) exp_q.push_back((b % 2 == 0) ? {1'b0, 8'hAA} : {1'b1, 8'h55});
        end
        r0d = {16{8'hAA}}; r1d = {16{8'h55}};
        r0v = 1'b1; r1v = 1'b1;
        for (int i = 0; i < 1000 && gnt_q.size() < 3; i++) @(negedge clk);
        r0v = 1'b0; r1v = 1'b0;
        for (int i = 0; i < 400 && busy === 1'b1; i++) @(negedge clk);
        checks++;
        if (gnt_q.size() != 3 || busy !== 1'b0) begin
            failures++; $display("FAIL both_grants got=%0d busy=%b want=3,0", gnt_q.size(), busy);
        end
        for (int i = 0; i < 3 && i < gnt_q.size(); i++) begin
            checks++;
            if (gnt_q[i] !== bit'(i % 2)) begin
                failures++; $display("FAIL both_order[%0d] got=%0d want=%0d", i, gnt_q[i], i % 2);
            end
        end
        if (gnt_done_q.size() >= 2) begin
            checks++;
            if (gnt_done_q[1] - d0 != 17) begin
                failures++; $display("FAIL both_ack1_timing dones=%0d want=17", gnt_done_q[1] - d0);
            end
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL both_len got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++; $display("FAIL both_byte[%0d] got=%h want=%h", i, o, e);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_spurious();
        logic [127:0] d;
        logic [8:0]   e, o;
        int           s0;
        resetn = 1'b0; @(negedge clk); resetn = 1'b1;
        s0 = start_cnt;
        si_done = 1'b1;
        repeat (3) @(negedge clk);
        si_done = 1'b0;
        checks++;
        if (busy !== 1'b0 || start_cnt != s0) begin
            failures++; $display("FAIL spur_idle busy=%b starts=%0d want=0,0", busy, start_cnt - s0);
        end
        d = 128'h0123456789ABCDEFFEDCBA9876543210;
        exp_q.push_back({1'b0, 8'hC0});
        for (int k = 0; k < 16; k++) exp_q.push_back({1'b0, d[127-8*k -: 8]});
        spur_en = 1'b1;
        r0d = d; r0v = 1'b1;
        @(negedge clk);
        r0v = 1'b0;
        for (int i = 0; i < 400 && busy === 1'b1; i++) @(negedge clk);
        spur_en = 1'b0;
        checks++;
        if (start_cnt - s0 != 17 || busy !== 1'b0) begin
            failures++; $display("FAIL spur_count starts=%0d busy=%b want=17,0", start_cnt - s0, busy);
        end
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++; $display("FAIL spur_byte[%0d] got=%h want=%h", i, o, e);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_notag();
        logic [127:0] d;
        logic [7:0]   e, o;
        int           s0;
        d = 128'h0F0E0D0C0B0A09080706050403020100;
        for (int k = 0; k < 16; k++) b_exp_q.push_back(d[127-8*k -: 8]);
        s0 = b_start_cnt;
        b_r1d = d; b_r1v = 1'b1;
        @(negedge clk);
        checks++;
        if (b_ack1 !== 1'b1 || b_ack0 !== 1'b0) begin
            failures++; $display("FAIL notag_ack ack1=%b ack0=%b want=1,0", b_ack1, b_ack0);
        end
        b_r1v = 1'b0;
        @(negedge clk);
        checks++;
        if (b_start !== 1'b1 || b_dout !== 8'h0F) begin
            failures++; $display("FAIL notag_first start=%b dout=%h want=1,0f", b_start, b_dout);
        end
        for (int i = 0; i < 400 && b_busy === 1'b1; i++) @(negedge clk);
        checks++;
        if (b_start_cnt - s0 != 16 || b_busy !== 1'b0) begin
            failures++; $display("FAIL notag_count starts=%0d busy=%b want=16,0", b_start_cnt - s0, b_busy);
        end
        for (int i = 0; b_exp_q.size() > 0 && b_obs_q.size() > 0; i++) begin
            e = b_exp_q.pop_front(); o = b_obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++; $display("FAIL notag_byte[%0d] got=%h want=%h", i, o, e);
            end
        end
        b_exp_q.delete(); b_obs_q.delete();
    endtask

    task automatic test_drop();
        logic [127:0] d;
        logic [8:0]   e, o;
        int           a0;
        d = 128'hFEEDFACECAFEBEEF0011223344556677;
        exp_q.push_back({1'b1, 8'hD1});
        for (int k = 0; k < 16; k++) exp_q.push_back({1'b1, d[127-8*k -: 8]});
        gnt_q.delete(); gnt_done_q.delete();
        a0 = ack0_cnt;
        r1d = d; r1v = 1'b1;
        @(negedge clk);
        r1v = 1'b0;
        repeat (5) @(negedge clk);
        r0d = {16{8'h3C}}; r0v = 1'b1;
        @(negedge clk);
        r0v = 1'b0;
        for (int i = 0; i < 400 && busy === 1'b1; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        checks++;
        if (ack0_cnt != a0 || gnt_q.size() != 1 || busy !== 1'b0) begin
            failures++; $display("FAIL drop_noserve ack0s=%0d grants=%0d busy=%b want=0,1,0", ack0_cnt - a0, gnt_q.size(), busy);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++; $display("FAIL drop_len got=%0d want=%0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++; $display("FAIL drop_byte[%0d] got=%h want=%h", i, o, e);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid();
        logic [127:0] d, d2;
        logic [8:0]   e, o;
        int           d0, s0, a0;
        resetn = 1'b0; @(negedge clk); resetn = 1'b1;
        d = 128'hA5A4A3A2A1A09F9E9D9C9B9A99989796;
        exp_q.push_back({1'b1, 8'hD1});
        for (int k = 0; k < 4; k++) exp_q.push_back({1'b1, d[127-8*k -: 8]});
        d0 = done_cnt;
        r1d = d; r1v = 1'b1;
        @(negedge clk);
        r1v = 1'b0;
        for (int i = 0; i < 200 && done_cnt - d0 < 5; i++) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        checks++;
        if ({ack0, ack1, start, busy, asrc, dout} !== 13'b0) begin
            failures++; $display("FAIL midreset_outs got=%b want=0", {ack0, ack1, start, busy, asrc, dout});
        end
        resetn = 1'b1;
        s0 = start_cnt; a0 = ack0_cnt + ack1_cnt;
        repeat (25) @(negedge clk);
        checks++;
        if (start_cnt != s0 || ack0_cnt + ack1_cnt != a0 || busy !== 1'b0) begin
            failures++; $display("FAIL midreset_quiet starts=%0d acks=%0d busy=%b want=0,0,0", start_cnt - s0, ack0_cnt + ack1_cnt - a0, busy);
        end
        checks++;
        if (obs_q.size() < 5) begin
            failures++; $display("FAIL midreset_len got=%0d want>=5", obs_q.size());
        end
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++; $display("FAIL midreset_byte[%0d] got=%h want=%h", i, o, e);
            end
        end
        exp_q.delete(); obs_q.delete();
        d2 = 128'h1122334455667788_99AABBCCDDEEFF00;
        exp_q.push_back({1'b0, 8'hC0});
        for (int k = 0; k < 16; k++) exp_q.push_back({1'b0, d2[127-8*k -: 8]});
        r0d = d2; r1d = {16{8'h77}};
        r0v = 1'b1; r1v = 1'b1;
        @(negedge clk);
        checks++;
        if (ack0 !== 1'b1 || ack1 !== 1'b0) begin
            failures++; $display("FAIL midreset_tie ack0=%b ack1=%b want=1,0", ack0, ack1);
        end
        r0v = 1'b0; r1v = 1'b0;
        for (int i = 0; i < 400 && busy === 1'b1; i++) @(negedge clk);
        checks++;
        if (obs_q.size() != exp_q.size() || busy !== 1'b0) begin
            failures++; $display("FAIL midreset_tie_len got=%0d busy=%b want=%0d,0", obs_q.size(), busy, exp_q.size());
        end
        for (int i = 0; exp_q.size() > 0 && obs_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                failures++; $display("FAIL midreset_tie_byte[%0d] got=%h want=%h", i, o, e);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        checks = 0; failures = 0;
        resetn = 1'b0; spur_en = 1'b0; si_done = 1'b0;
        r0v = 1'b0; r1v = 1'b0; r0d = '0; r1d = '0;
        b_r0v = 1'b0; b_r1v = 1'b0; b_r0d = '0; b_r1d = '0;
        test_reset();
        test_single();
        test_both();
        test_spurious();
        test_notag();
        test_drop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
